// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad front end: FSM encoding, key codes and
// the row/column to key-code map.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_A     = 4'd10;
    localparam logic [3:0] KEY_B     = 4'd11;
    localparam logic [3:0] KEY_C     = 4'd12;
    localparam logic [3:0] KEY_D     = 4'd13;
    localparam logic [3:0] KEY_STAR  = 4'd14;
    localparam logic [3:0] KEY_HASH  = 4'd15;

    localparam logic [3:0] COL_FIRST = 4'b1110;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = KEY_A;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = KEY_B;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'hA:    code = 4'd9;
            4'hB:    code = KEY_C;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'd0;
            4'hE:    code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

    // Exactly one active-low bit set; multiple low rows are ghosting, not a key.
    function automatic logic one_low(input logic [3:0] pat);
        return (pat == 4'b1110) || (pat == 4'b1101) ||
               (pat == 4'b1011) || (pat == 4'b0111);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] pat);
        logic [1:0] idx;
        case (pat)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] rotl(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

endpackage

// File: rtl/keypad_scanner_tick.sv
// Free-running prescaler producing a one-cycle tick every CLK_DIV clocks.
module scan_tick_gen #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              count <= '0;
        else if (count == LAST) count <= '0;
        else                    count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row synchronise/debounce, key encoding.
//   state    | meaning
//   SCAN     | rotating columns, waiting for a single low row
//   DEBOUNCE | column held, counting matching samples of the captured row
//   PRESSED  | key accepted and strobed, waiting for rows to go idle
//   RELEASE  | counting idle samples; any low row falls back to PRESSED
module keypad_scanner import keypad_pkg::*; #(
    parameter int CLK_DIV        = 1000,
    parameter int DEBOUNCE_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] digit_out,
    output logic       load,
    output logic       func_key,
    output logic       key_held
);
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_TICKS);

    logic       tick;
    logic [3:0] row_meta, row_s;
    state_t     state, state_nxt;
    logic [3:0] cap_row, cap_row_nxt;
    logic [3:0] col_nxt, digit_nxt, code_now;
    logic [7:0] count, count_nxt;
    logic       load_nxt, func_nxt, held_nxt;

    scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // The column stays parked while debouncing, so col_out is the captured column.
    assign code_now = key_code(low_index(cap_row), low_index(col_out));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_meta  <= 4'hF;
            row_s     <= 4'hF;
            state     <= SCAN;
            cap_row   <= ROWS_IDLE;
            count     <= '0;
            col_out   <= COL_FIRST;
            digit_out <= '0;
            load      <= 1'b0;
            func_key  <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            row_meta  <= row_in;
            row_s     <= row_meta;
            state     <= state_nxt;
            cap_row   <= cap_row_nxt;
            count     <= count_nxt;
            col_out   <= col_nxt;
            digit_out <= digit_nxt;
            load      <= load_nxt;
            func_key  <= func_nxt;
            key_held  <= held_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cap_row_nxt = cap_row;
        col_nxt     = col_out;
        count_nxt   = count;
        digit_nxt   = digit_out;
        load_nxt    = 1'b0;
        func_nxt    = 1'b0;
        held_nxt    = key_held;
        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (one_low(row_s)) begin
                        cap_row_nxt = row_s;
                        count_nxt   = 8'd1;
                        state_nxt   = DEBOUNCE;
                    end else begin
                        col_nxt = rotl(col_out);
                    end
                end
                DEBOUNCE: begin
                    if (row_s == cap_row) begin
                        count_nxt = count + 8'd1;
                        if (count_nxt == DB_LAST) begin
                            state_nxt = PRESSED;
                            digit_nxt = code_now;
                            held_nxt  = 1'b1;
                            if (code_now <= 4'd9) load_nxt = 1'b1;
                            else                  func_nxt = 1'b1;
                        end
                    end else begin
                        state_nxt = SCAN;
                        col_nxt   = rotl(col_out);
                        count_nxt = '0;
                    end
                end
                PRESSED: begin
                    if (row_s == ROWS_IDLE) begin
                        count_nxt = 8'd1;
                        state_nxt = RELEASE;
                    end
                end
                RELEASE: begin
                    if (row_s == ROWS_IDLE) begin
                        count_nxt = count + 8'd1;
                        if (count_nxt == DB_LAST) begin
                            state_nxt = SCAN;
                            held_nxt  = 1'b0;
                            col_nxt   = rotl(col_out);
                            count_nxt = '0;
                        end
                    end else begin
                        state_nxt = PRESSED;
                        count_nxt = '0;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows from col_out,
// expected strobes are queued by the stimulus and popped by a strobe monitor.
module tb_keypad_scanner;
    localparam int CLK_DIV = 4;
    localparam int DT      = 3;

    typedef struct packed {
        logic       is_func;
        logic [3:0] code;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out, digit_out;
    logic        load, func_key, key_held;
    logic [15:0] keys = '0;
    logic [15:0] hist = '0;
    logic        unlocked;
    int          pc;
    logic        tb_tick;
    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          strobes = 0;
    int          pushes = 0;

    always #5 clk = ~clk;

    keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE_TICKS(DT)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .digit_out (digit_out),
        .load      (load),
        .func_key  (func_key),
        .key_held  (key_held)
    );

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) pc <= 0;
        else       pc <= (pc == CLK_DIV - 1) ? 0 : pc + 1;
    end
    assign tb_tick  = (pc == CLK_DIV - 1);
    assign unlocked = (hist == 16'h4321);

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_key(input logic [3:0] code);
        exp_t e;
        e.is_func = (code > 4'd9);
        e.code    = code;
        exp_q.push_back(e);
        pushes++;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (!tb_tick) @(negedge clk);
            @(posedge clk);
        end
    endtask

    task automatic wait_col(input logic [3:0] target, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (col_out == target && n < 100) begin @(negedge clk); n++; end
        while (col_out != target && n < 100) begin @(negedge clk); n++; end
        check(name, 16'(col_out), 16'(target));
    endtask

    task automatic wait_held(input logic val, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (key_held !== val && n < 200) begin @(negedge clk); n++; end
        check(name, 16'(key_held), 16'(val));
    endtask

    task automatic press_release(input int r, input int c, input logic [3:0] code);
        expect_key(code);
        keys[r*4+c] = 1'b1;
        wait_held(1'b1, "held_rise");
        check("strobe_at_accept", 16'(load | func_key), 16'd1);
        check("digit_at_accept", 16'(digit_out), 16'(code));
        keys = '0;
        wait_held(1'b0, "held_fall");
        check("digit_hold", 16'(digit_out), 16'(code));
    endtask

    // Strobe monitor: every load/func_key pulse must match the head of the queue.
    initial begin
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (load || func_key) begin
                    strobes++;
                    check("strobe_one_hot", 16'(load & func_key), 16'd0);
                    check("strobe_one_cycle", 16'(prev), 16'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: got code %0d load %0b func %0b, required no strobe",
                                 digit_out, load, func_key);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe_kind", 16'(func_key), 16'(e.is_func));
                        check("strobe_code", 16'(digit_out), 16'(e.code));
                    end
                    if (load) hist = {hist[11:0], digit_out};
                    else      hist = '0;
                end
                prev = load | func_key;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] col_seq [4];
        col_seq[0] = 4'b1101;
        col_seq[1] = 4'b1011;
        col_seq[2] = 4'b0111;
        col_seq[3] = 4'b1110;

        repeat (3) @(negedge clk);
        check("rst_col", 16'(col_out), 16'h000E);
        check("rst_digit", 16'(digit_out), 16'd0);
        check("rst_load", 16'(load), 16'd0);
        check("rst_func", 16'(func_key), 16'd0);
        check("rst_held", 16'(key_held), 16'd0);
        reset = 1'b0;

        // Idle scanning: one column step per tick.
        for (int i = 0; i < 8; i++) begin
            wait_ticks(1);
            @(negedge clk);
            check("idle_col", 16'(col_out), 16'(col_seq[i % 4]));
        end

        // Key 5 with exact press and release latency.
        expect_key(4'd5);
        keys[5] = 1'b1;
        wait_col(4'b1101, "wait_col1");
        wait_ticks(2);
        @(negedge clk);
        check("k5_not_yet", 16'(key_held), 16'd0);
        wait_ticks(1);
        @(negedge clk);
        check("k5_held", 16'(key_held), 16'd1);
        check("k5_load", 16'(load), 16'd1);
        check("k5_digit", 16'(digit_out), 16'd5);
        keys = '0;
        wait_ticks(2);
        @(negedge clk);
        check("k5_still_held", 16'(key_held), 16'd1);
        wait_ticks(1);
        @(negedge clk);
        check("k5_released", 16'(key_held), 16'd0);

        // Code entry 4-3-2-1 into the lock model.
        press_release(1, 0, 4'd4);
        press_release(0, 2, 4'd3);
        press_release(0, 1, 4'd2);
        press_release(0, 0, 4'd1);
        check("lock_unlocked", 16'(unlocked), 16'd1);

        press_release(3, 2, 4'd15);

        // Bounce during debounce: released before the second sample.
        keys[5] = 1'b1;
        wait_col(4'b1101, "bounce_col1");
        wait_ticks(1);
        @(negedge clk);
        keys = '0;
        wait_ticks(1);
        @(negedge clk);
        check("bounce_rescan", 16'(col_out), 16'h000B);
        check("bounce_no_held", 16'(key_held), 16'd0);

        // Release bounce of one tick while held.
        expect_key(4'd5);
        keys[5] = 1'b1;
        wait_held(1'b1, "rb_held");
        keys = '0;
        wait_ticks(1);
        @(negedge clk);
        keys[5] = 1'b1;
        wait_ticks(1);
        @(negedge clk);
        check("rb_still_held", 16'(key_held), 16'd1);
        keys = '0;
        wait_held(1'b0, "rb_release");

        // Two rows on one column (5 and 8) are rejected.
        keys[5] = 1'b1;
        keys[9] = 1'b1;
        wait_col(4'b1101, "multi_col1");
        wait_ticks(1);
        @(negedge clk);
        check("multi_rotates", 16'(col_out), 16'h000B);
        wait_ticks(6);
        @(negedge clk);
        check("multi_no_held", 16'(key_held), 16'd0);
        keys = '0;

        // Reset while PRESSED, then a clean press.
        expect_key(4'd7);
        keys[8] = 1'b1;
        wait_held(1'b1, "pre_rst_held");
        reset = 1'b1;
        #1;
        check("mid_rst_col", 16'(col_out), 16'h000E);
        check("mid_rst_digit", 16'(digit_out), 16'd0);
        check("mid_rst_held", 16'(key_held), 16'd0);
        check("mid_rst_strobes", 16'(load | func_key), 16'd0);
        keys = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        press_release(2, 2, 4'd9);

        wait_ticks(4);
        @(negedge clk);
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        check("strobe_total", 16'(strobes), 16'(pushes));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Front-end stage for the digital lock. Scans a 4x4 matrix keypad, synchronises and debounces the row returns, and encodes each accepted keypress.
- Digit keys (0-9) produce a 4-bit code plus a one-cycle load strobe that feeds the lock FSM's digit_in/load inputs directly.
- Non-digit keys (A-D, *, #) produce a separate strobe so the system can use them as clear/enter functions.

Parameters:
- CLK_DIV, 1000, clk cycles per scan tick; range 2..65535.
- DEBOUNCE_TICKS, 8, consecutive identical scan ticks required to accept a press or a release; range 2..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col_out  out  4  keypad column drive, active-low, exactly one bit low at all times
- digit_out  out  4  code of last accepted key, held until the next accepted key
- load  out  1  one-cycle pulse, accepted key code is 0..9
- func_key  out  1  one-cycle pulse, accepted key code is 10..15
- key_held  out  1  high from acceptance until release is debounced

Behaviour:
- Reset values (asynchronous, active-high): col_out=4'b1110, digit_out=0, load=0, func_key=0, key_held=0, synchroniser=4'hF, prescaler=0, state=SCAN, debounce count=0.
- row_in passes through a 2-flop synchroniser before any use. All logic below samples the synchronised rows only on tick.
- tick: one-cycle pulse every CLK_DIV clk cycles, from a free-running prescaler counting 0..CLK_DIV-1. tick is high when the count equals CLK_DIV-1.
- Key map, row r / col c -> code:
  - r0: 1, 2, 3, A(10)
  - r1: 4, 5, 6, B(11)
  - r2: 7, 8, 9, C(12)
  - r3: *(14), 0, #(15), D(13)
- Valid pattern: exactly one row bit low. Any other non-all-high pattern (multiple rows low) is invalid.
- FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE. All transitions occur only on tick.
- SCAN:
  - Valid pattern: capture the row pattern and current column, set count=1, go to DEBOUNCE. The column is held.
  - Otherwise: rotate col_out left by one (1110 -> 1101 -> 1011 -> 0111 -> 1110).
- DEBOUNCE:
  - Rows equal the captured pattern: count++.
  - When count reaches DEBOUNCE_TICKS: go to PRESSED, write the code to digit_out, and pulse load or func_key in the next clk cycle.
  - Mismatch: go to SCAN, advance column, count=0.
- PRESSED:
  - key_held=1. No further strobes.
  - All rows high: count=1, go to RELEASE.
- RELEASE:
  - All rows high: count++. When count reaches DEBOUNCE_TICKS: go to SCAN, key_held=0, advance column.
  - Any row low: return to PRESSED with no new strobe (bounce on release).
- Strobes:
  - Exactly one of load/func_key pulses, for exactly one clk cycle, per accepted press.
  - digit_out is stable in the strobe cycle and afterwards.
- Press latency: DEBOUNCE_TICKS ticks from the first valid sample, plus 1 clk cycle to the strobe.
- A key held indefinitely produces one strobe only (no auto-repeat).
- A second key pressed while one is held is ignored. The column stays fixed, so only a change on the held column's rows matters, and that is handled as bounce.
- reset mid-debounce or mid-press: all state returns to reset values immediately. No strobe is generated.

Decomposition:
- Shared package keypad_pkg:
  - state encoding (SCAN=0, DEBOUNCE=1, PRESSED=2, RELEASE=3)
  - key code constants (KEY_A..KEY_D, KEY_STAR=14, KEY_HASH=15)
  - the 16-entry row/col-to-code map as a constant function
- One sub-module, scan_tick_gen: parameter CLK_DIV, ports clk/reset/tick. Reused by later display-multiplex blocks.

Test Plan (CLK_DIV=4, DEBOUNCE_TICKS=3):
- Reset released, no keys -> col_out cycles 1110, 1101, 1011, 0111 with a 4-clk period per column; load/func_key never assert.
- Press key "5" (row1 low while col1 driven), held clean -> after 3 ticks digit_out=5, one load pulse, key_held=1. Release -> key_held=0 after 3 all-high ticks.
- Press "4", "3", "2", "1" in sequence, each cleanly released -> four load pulses with digit_out 4, 3, 2, 1. The bench feeds the lock model and checks unlocked=1.
- Press "#" (row3, col2) -> func_key pulses once with digit_out=15; load stays 0.
- Bounce: row toggles at tick 2 of debounce -> no strobe, scanning resumes. Release-bounce of 1 tick while held -> still only one strobe total.
- Two rows low on the same column -> no strobe. Assert reset during PRESSED -> outputs return to reset values at once, no strobe; a clean press afterwards works normally.
